// File: rtl/api_reader.sv
// Read-side host command decoder: parses READ_MEM / READ_REG headers from the inbound
// byte stream and returns SDRAM words or a 32-bit register through the outbound stream.
module api_reader #(
  parameter logic [7:0] CMD_READ_MEM = 8'd2,
  parameter logic [7:0] CMD_READ_REG = 8'd4,
  parameter logic [7:0] FILL_BYTE    = 8'h00
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  output logic        ram_req_o,
  output logic        ram_we_o,
  output logic [1:0]  ram_wm_o,
  output logic [21:0] ram_address_o,
  input  logic [15:0] ram_data_read_i,
  input  logic        ram_busy_i,
  input  logic [31:0] rd_reg_i,
  output logic [3:0]  rd_reg_addr_o,
  input  logic [7:0]  rd_data_i,
  input  logic        rd_valid_i,
  output logic        rd_ready_o,
  output logic [7:0]  wr_data_o,
  input  logic        wr_valid_i,
  output logic        wr_ready_o,
  input  logic        start_i
);

  typedef enum logic [2:0] {
    S_CMD, S_ADDR, S_FETCH, S_WAIT, S_SEND, S_REG_LATCH, S_SEND_REG, S_IDLE_FILL
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [21:0] address_q, address_d;
  logic        hi_sel_q, hi_sel_d;
  logic [15:0] word_buf_q, word_buf_d;
  logic [31:0] reg_buf_q, reg_buf_d;
  logic [3:0]  rd_reg_addr_q, rd_reg_addr_d;
  logic        rd_ready_q, rd_ready_d;
  logic        wr_ready_q, wr_ready_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        ram_req_q, ram_req_d;
  logic        busy_q;

  logic rd_acc, wr_req, is_mem, is_reg;

  assign rd_acc = rd_valid_i && !rd_ready_q;
  assign wr_req = wr_valid_i && !wr_ready_q;
  assign is_mem = (cmd_q == CMD_READ_MEM);
  assign is_reg = (cmd_q == CMD_READ_REG);

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    byte_cnt_d    = byte_cnt_q;
    address_d     = address_q;
    hi_sel_d      = hi_sel_q;
    word_buf_d    = word_buf_q;
    reg_buf_d     = reg_buf_q;
    rd_reg_addr_d = rd_reg_addr_q;
    wr_data_d     = wr_data_q;
    rd_ready_d    = 1'b0;
    wr_ready_d    = 1'b0;
    ram_req_d     = 1'b0;

    if (start_i) begin
      state_d = S_CMD;
    end else begin
      // Inbound bytes are always acked; only CMD/ADDR give them meaning.
      rd_ready_d = rd_acc;
      case (state_q)
        S_CMD: begin
          if (rd_acc) begin
            cmd_d      = rd_data_i;
            byte_cnt_d = 2'd0;
            state_d    = S_ADDR;
          end
          if (wr_req) begin
            wr_ready_d = 1'b1;
            wr_data_d  = FILL_BYTE;
          end
        end
        S_ADDR: begin
          if (rd_acc) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            case (byte_cnt_q)
              2'd0: if (is_mem) address_d[21:15] = rd_data_i[6:0];
              2'd1: if (is_mem) address_d[14:7] = rd_data_i;
              default: begin
                if (is_mem) {address_d[6:0], hi_sel_d} = rd_data_i;
                if (is_reg) rd_reg_addr_d = rd_data_i[3:0];
                byte_cnt_d = 2'd0;
                state_d    = is_mem ? S_FETCH : (is_reg ? S_REG_LATCH : S_IDLE_FILL);
              end
            endcase
          end
          if (wr_req) begin
            wr_ready_d = 1'b1;
            wr_data_d  = FILL_BYTE;
          end
        end
        S_FETCH: begin
          if (!ram_busy_i) begin
            ram_req_d = 1'b1;
            state_d   = S_WAIT;
          end
        end
        S_WAIT: begin
          // Data is valid on the cycle busy drops after having been seen high.
          if (busy_q && !ram_busy_i) begin
            word_buf_d = ram_data_read_i;
            state_d    = S_SEND;
          end
        end
        S_SEND: begin
          if (wr_req) begin
            wr_ready_d = 1'b1;
            if (!hi_sel_q) begin
              wr_data_d = word_buf_q[7:0];
              hi_sel_d  = 1'b1;
            end else begin
              wr_data_d = word_buf_q[15:8];
              hi_sel_d  = 1'b0;
              address_d = address_q + 22'd1;
              state_d   = S_FETCH;
            end
          end
        end
        S_REG_LATCH: begin
          // rd_reg lags rd_reg_addr by a cycle, so sample on the second cycle here.
          if (byte_cnt_q == 2'd0) begin
            byte_cnt_d = 2'd1;
          end else begin
            reg_buf_d  = rd_reg_i;
            byte_cnt_d = 2'd0;
            state_d    = S_SEND_REG;
          end
        end
        S_SEND_REG: begin
          if (wr_req) begin
            wr_ready_d = 1'b1;
            wr_data_d  = reg_buf_q[{byte_cnt_q, 3'b000} +: 8];
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) state_d = S_IDLE_FILL;
          end
        end
        S_IDLE_FILL: begin
          if (wr_req) begin
            wr_ready_d = 1'b1;
            wr_data_d  = FILL_BYTE;
          end
        end
        default: state_d = S_CMD;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q       <= S_CMD;
      cmd_q         <= 8'h00;
      byte_cnt_q    <= 2'd0;
      address_q     <= 22'd0;
      hi_sel_q      <= 1'b0;
      word_buf_q    <= 16'h0000;
      reg_buf_q     <= 32'h0;
      rd_reg_addr_q <= 4'd0;
      rd_ready_q    <= 1'b0;
      wr_ready_q    <= 1'b0;
      wr_data_q     <= FILL_BYTE;
      ram_req_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      byte_cnt_q    <= byte_cnt_d;
      address_q     <= address_d;
      hi_sel_q      <= hi_sel_d;
      word_buf_q    <= word_buf_d;
      reg_buf_q     <= reg_buf_d;
      rd_reg_addr_q <= rd_reg_addr_d;
      rd_ready_q    <= rd_ready_d;
      wr_ready_q    <= wr_ready_d;
      wr_data_q     <= wr_data_d;
      ram_req_q     <= ram_req_d;
      busy_q        <= ram_busy_i;
    end
  end

  assign ram_req_o     = ram_req_q;
  assign ram_we_o      = 1'b0;
  assign ram_wm_o      = 2'b00;
  assign ram_address_o = address_q;
  assign rd_reg_addr_o = rd_reg_addr_q;
  assign rd_ready_o    = rd_ready_q;
  assign wr_ready_o    = wr_ready_q;
  assign wr_data_o     = wr_data_q;

endmodule
